onehot_state_reg: RTL
=====================

# onehot_state_reg

State-holding stage for the four-state one-hot Moore machine (states A, B, C, D on bits 0..3). It sits directly upstream of the combinational next-state decoder. It drives the decoder's `state` input from a register and loads the decoder's `next_state` back on each enabled clock. It also checks every load for one-hot legality, recovers to state A on a corrupt vector, and counts entries into state D for the monitor logic.

## Interface
Parameters:
- `CNT_W`, 8: width of the D-entry counter.
- `RESET_STATE`, 4'b0001: one-hot state loaded on reset and on recovery. Must have exactly one bit set.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `en`  in  1  advance enable; 1 = load `next_state` this cycle.
- `next_state`  in  4  one-hot vector from the next-state decoder.
- `cnt_clr`  in  1  synchronous clear of `d_count`/`d_sat`.
- `err_clr`  in  1  synchronous clear of `err`.
- `state`  out  4  registered one-hot state, fed to the decoder.
- `out`  out  1  Moore output, equal to `state[3]` (state D).
- `d_count`  out  CNT_W  number of entries into D, saturating.
- `d_sat`  out  1  sticky; set when `d_count` reaches all-ones.
- `err`  out  1  sticky illegal-vector flag.
- `recover`  out  1  one-cycle pulse; 1 in the cycle after a recovery load.

## Operation
- Reset (`resetn`=0 at an edge) sets `state`=RESET_STATE, `d_count`=0, `d_sat`=0, `err`=0, `recover`=0. Reset overrides every other input.
- Legal vector: exactly one bit set. Both 4'b0000 and any vector with two or more bits set are illegal.
- `en`=1 with a legal `next_state`: `state` <= `next_state`.
- `en`=1 with an illegal `next_state`: `state` <= RESET_STATE, `err` <= 1, `recover` <= 1.
- Held-state check: if `state` itself is illegal (upset), the block recovers to RESET_STATE on the next edge regardless of `en`, setting `err` and `recover`. This check has priority over the `en` load.
- `en`=0 with a legal `state`: `state` holds.
- `recover` is 0 in every cycle that does not follow a recovery load. Back-to-back recoveries hold it at 1.
- D entry: a legal load with `next_state[3]`=1 while `state[3]`=0. Each entry increments `d_count` by 1, saturating at 2^CNT_W−1, where `d_sat` is set.
  - A recovery load is never counted as an entry, even if RESET_STATE is D.
- `cnt_clr`=1: `d_count` <= 0 and `d_sat` <= 0. If a D entry occurs in the same cycle, `d_count` <= 1.
- `err_clr`=1 clears `err`. A simultaneous new illegal event wins, so `err` stays 1.
- `out` = `state[3]`. It is a direct bit of the state register, so it is glitch-free.

## Timing
- Every output is registered. One cycle elapses from `next_state`/`en` sampling to a visible `state`.
- The decoder loop (`state` → decoder → `next_state` → this block) is one register deep, giving one state transition per enabled cycle.
- `recover` and `err` assert in the same cycle that `state` shows RESET_STATE after a recovery.
- `d_count` updates in the same cycle that `state[3]` first reads 1.
- No combinational path from any input to any output.

## Configuration
- `ONEHOT_CHECK_EN` defined: legality checks, recovery, `err` and `recover` behave as above.
- Undefined:
  - `next_state` is loaded verbatim whenever `en`=1, with no held-state check.
  - `err` and `recover` are tied to 0; `err_clr` is ignored.
  - D-entry counting still applies to every `en`=1 load with `next_state[3]`=1 and `state[3]`=0.

## Test plan
- Reset: drive `resetn`=0 for 2 cycles, then release → `state`=0001, `out`=0, `d_count`=0, `err`=0, `recover`=0.
- Legal walk: with `en`=1, feed 0010, 1000, 0100, 1000 on consecutive cycles → `state` follows one cycle later, `out`=1 twice, `d_count`=2.
- Enable hold: `en`=0 with `next_state`=1000 for 3 cycles → `state` is unchanged and `d_count` is unchanged.
- Illegal load (check on): `en`=1, `next_state`=0110 → next cycle `state`=0001, `err`=1, `recover`=1 for exactly one cycle. Then `err_clr`=1 → `err`=0.
- Saturation/clear: `CNT_W`=2, four D entries → `d_count`=3, `d_sat`=1. Then `cnt_clr` coincident with a D entry → `d_count`=1, `d_sat`=0.
- Check off (macro undefined): `next_state`=0000 with `en`=1 → `state`=0000, `err`=0, `recover`=0.

Source files
------------

// File: rtl/onehot_state_reg.sv
// rtl/onehot_state_reg.sv - registered one-hot state for a 4-state Moore FSM with D-entry counter
// Optional feature macro: ONEHOT_CHECK_EN (one-hot legality check, recovery, err/recover flags)
module onehot_state_reg #(
  parameter int         CNT_W       = 8,
  parameter logic [3:0] RESET_STATE = 4'b0001
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [3:0]       next_state,
  input  logic             cnt_clr,
  input  logic             err_clr,
  output logic [3:0]       state,
  output logic             out,
  output logic [CNT_W-1:0] d_count,
  output logic             d_sat,
  output logic             err,
  output logic             recover
);

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_d_count;
  logic             r_d_sat;
  logic             w_legal_load;
  logic             w_recover_load;
  logic             w_d_entry;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef ONEHOT_CHECK_EN
  logic r_err;
  logic r_recover;
  logic w_ns_legal;
  logic w_st_legal;

  assign w_ns_legal = $onehot(next_state);
  assign w_st_legal = $onehot(r_state);

  // An upset held state forces recovery even while the machine is stalled.
  assign w_recover_load = !w_st_legal || (en && !w_ns_legal);
  assign w_legal_load   = en && !w_recover_load;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err     <= 1'b0;
      r_recover <= 1'b0;
    end else begin
      r_recover <= w_recover_load;
      if (w_recover_load) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err     = r_err;
  assign recover = r_recover;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign w_recover_load   = 1'b0;
  assign w_legal_load     = en;
  assign err              = 1'b0;
  assign recover          = 1'b0;
`endif

  assign w_d_entry = w_legal_load && next_state[3] && !r_state[3];
  assign w_cnt_inc = r_d_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= RESET_STATE;
    end else if (w_recover_load) begin
      r_state <= RESET_STATE;
    end else if (w_legal_load) begin
      r_state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_d_count <= '0;
      r_d_sat   <= 1'b0;
    end else if (cnt_clr) begin
      r_d_count <= w_d_entry ? CNT_W'(1) : '0;
      r_d_sat   <= 1'b0;
    end else if (w_d_entry && !(&r_d_count)) begin
      r_d_count <= w_cnt_inc;
      if (&w_cnt_inc) begin
        r_d_sat <= 1'b1;
      end
    end
  end

  assign state   = r_state;
  assign out     = r_state[3];
  assign d_count = r_d_count;
  assign d_sat   = r_d_sat;

endmodule
